// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode selectors, default
// threshold margins and a clog2 helper for callers sizing address ports.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Default distance of the almost-full / almost-empty thresholds from the ends
    localparam int AFULL_MARGIN  = 4;
    localparam int AEMPTY_MARGIN = 4;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The output register has a synchronous reset so it maps onto a block RAM
// output latch; the array itself is never cleared.
module fifo_ram_dp #(
    parameter int ADDRBITS = 11,
    parameter int DATABITS = 8
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                wr_en,
    input  logic [ADDRBITS-1:0] wr_addr,
    input  logic [DATABITS-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDRBITS-1:0] rd_addr,
    output logic [DATABITS-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDRBITS;

    logic [DATABITS-1:0] mem_reg [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-address write in the same cycle returns the old word
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_ram_level.sv
// Single-clock FIFO over an inferred block RAM with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a standard or first-word-fall-through read mode.
module fifo_ram_level
    import fifo_pkg::*;
#(
    parameter int ADDRBITS     = 11,
    parameter int DATABITS     = 8,
    parameter int FWFT         = FIFO_MODE_STD,
    parameter int AFULL_LEVEL  = 2 ** ADDRBITS - AFULL_MARGIN,
    parameter int AEMPTY_LEVEL = AEMPTY_MARGIN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [DATABITS-1:0] write_data,
    input  logic                write_en,
    output logic [DATABITS-1:0] read_data,
    input  logic                read_en,
    output logic                empty,
    output logic                full,
    output logic [ADDRBITS:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 2 ** ADDRBITS;
    localparam logic [ADDRBITS:0]   DEPTH_C  = DEPTH[ADDRBITS:0];
    localparam logic [ADDRBITS:0]   AFULL_C  = AFULL_LEVEL[ADDRBITS:0];
    localparam logic [ADDRBITS:0]   AEMPTY_C = AEMPTY_LEVEL[ADDRBITS:0];
    localparam logic [ADDRBITS-1:0] PTR_ONE  = {{(ADDRBITS-1){1'b0}}, 1'b1};
    localparam logic [ADDRBITS:0]   CNT_ONE  = {{ADDRBITS{1'b0}}, 1'b1};

    // Reject threshold / mode settings that cannot describe a valid FIFO
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("fifo_ram_level: AFULL_LEVEL must be in 1..DEPTH");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_ram_level: AEMPTY_LEVEL must be in 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_ram_level: FWFT must be 0 or 1");
    end

    logic [ADDRBITS-1:0] wr_ptr_reg;
    logic [ADDRBITS-1:0] rd_ptr_reg;
    logic [ADDRBITS:0]   count_reg;
    logic [ADDRBITS:0]   count_next;
    logic                overflow_reg;
    logic                underflow_reg;

    logic                empty_int;
    logic                full_int;
    logic                rd_acc;
    logic                wr_acc;
    // RAM read issued this cycle; also advances the read pointer
    logic                rd_advance;
    logic                ram_we;
    logic                ram_re;

    // Accept decode from registered state; a pop frees a slot for a push when full
    always_comb begin
        full_int = (count_reg == DEPTH_C);
        rd_acc   = read_en & ~empty_int;
        wr_acc   = write_en & (~full_int | rd_acc);
        ram_we   = wr_acc & ~flush & ~rst;
        ram_re   = rd_advance & ~flush;
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        logic              out_valid_reg;
        logic [ADDRBITS:0] ram_words;

        // The RAM output register is the head slot; refill it when it empties or is popped
        always_comb begin
            ram_words  = count_reg - {{ADDRBITS{1'b0}}, out_valid_reg};
            rd_advance = (ram_words != '0) & (~out_valid_reg | rd_acc);
        end

        // Track whether the head slot holds a live word
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                out_valid_reg <= 1'b0;
            end else if (rd_advance) begin
                out_valid_reg <= 1'b1;
            end else if (rd_acc) begin
                out_valid_reg <= 1'b0;
            end
        end

        assign empty_int = ~out_valid_reg;
    end else begin : g_std
        assign rd_advance = rd_acc;
        assign empty_int  = (count_reg == '0);
    end

    // Next occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy and sticky error flags; rst and flush clear everything here
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_advance) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
            if (write_en && !wr_acc) begin
                overflow_reg <= 1'b1;
            end
            if (read_en && empty_int) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    fifo_ram_dp #(
        .ADDRBITS (ADDRBITS),
        .DATABITS (DATABITS)
    ) u_ram (
        .clk     (clk),
        .srst    (rst),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (write_data),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_reg),
        .rd_data (read_data)
    );

    assign empty        = empty_int;
    assign full         = full_int;
    assign count        = count_reg;
    assign almost_full  = (count_reg >= AFULL_C);
    assign almost_empty = (count_reg <= AEMPTY_C);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_ram_level.sv
// Directed bench for fifo_ram_level: one standard-mode and one FWFT instance
// sharing a clock, with a queue scoreboard holding the words expected out.
module tb_fifo_ram_level;

    localparam int AB    = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    // standard-mode instance
    logic          s_flush = 1'b0, s_we = 1'b0, s_re = 1'b0;
    logic [DB-1:0] s_wd = '0, s_rd;
    logic          s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic [AB:0]   s_count;
    // FWFT instance
    logic          f_flush = 1'b0, f_we = 1'b0, f_re = 1'b0;
    logic [DB-1:0] f_wd = '0, f_rd;
    logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [AB:0]   f_count;

    int n_assert = 0;
    int n_fail   = 0;
    int s_cnt_m  = 0;
    logic [7:0] sq[$];
    logic [7:0] fq[$];

    fifo_ram_level #(.ADDRBITS(AB), .DATABITS(DB), .FWFT(0), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)) u_std (
        .clk(clk), .rst(rst), .flush(s_flush), .write_data(s_wd), .write_en(s_we),
        .read_data(s_rd), .read_en(s_re), .empty(s_empty), .full(s_full), .count(s_count),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_ram_level #(.ADDRBITS(AB), .DATABITS(DB), .FWFT(1), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .write_data(f_wd), .write_en(f_we),
        .read_data(f_rd), .read_en(f_re), .empty(f_empty), .full(f_full), .count(f_count),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p, input logic [7:0] rd, input logic e, input logic f,
                             input logic [4:0] c, input logic af, input logic ae,
                             input logic ov, input logic un);
        chk({p, ".read_data"},    rd, 8'h00);
        chk({p, ".count"},        c,  5'd0);
        chk({p, ".empty"},        e,  1'b1);
        chk({p, ".full"},         f,  1'b0);
        chk({p, ".almost_empty"}, ae, 1'b1);
        chk({p, ".almost_full"},  af, 1'b0);
        chk({p, ".overflow"},     ov, 1'b0);
        chk({p, ".underflow"},    un, 1'b0);
    endtask

    // One standard-mode transaction; the scoreboard predicts acceptance from its own count
    task automatic s_op(input bit we, input logic [7:0] wd, input bit re, input string tag);
        bit racc, wacc;
        logic [7:0] e;
        e    = 8'h00;
        racc = re && (s_cnt_m != 0);
        wacc = we && ((s_cnt_m != DEPTH) || racc);
        if (racc) e = sq.pop_front();
        if (wacc) sq.push_back(wd);
        s_we = we; s_wd = wd; s_re = re;
        tick();
        s_we = 1'b0; s_re = 1'b0;
        s_cnt_m = s_cnt_m + int'(wacc) - int'(racc);
        $display("std %s: we=%0b wd=%02h re=%0b -> count=%0d read_data=%02h", tag, we, wd, re, s_count, s_rd);
        if (racc) chk({tag, ".data"}, s_rd, e);
        chk({tag, ".count"}, s_count, s_cnt_m);
    endtask

    initial begin
        // ---- reset ----
        tick();
        rst = 1'b0;
        chk_reset("rst_std",  s_rd, s_empty, s_full, s_count, s_af, s_ae, s_ovf, s_unf);
        chk_reset("rst_fwft", f_rd, f_empty, f_full, f_count, f_af, f_ae, f_ovf, f_unf);

        // ---- 1: standard single write/read ----
        s_op(1, 8'h07, 0, "t1_wr");
        chk("t1_not_empty", s_empty, 1'b0);
        s_op(0, 8'h00, 1, "t1_rd");
        chk("t1_rd_07", s_rd, 8'h07);
        chk("t1_empty", s_empty, 1'b1);
        s_op(1, 8'hFA, 0, "t1_wfa");
        s_op(1, 8'h1B, 0, "t1_w1b");
        s_op(0, 8'h00, 1, "t1_rfa");
        chk("t1_rd_fa", s_rd, 8'hFA);
        s_op(0, 8'h00, 1, "t1_r1b");
        chk("t1_no_unf", s_unf, 1'b0);
        s_op(0, 8'h00, 1, "t1_runder");
        chk("t1_unf", s_unf, 1'b1);
        chk("t1_rd_held", s_rd, 8'h1B);

        // ---- 2: fill to full, thresholds, overflow ----
        for (int i = 0; i < 16; i++) begin
            s_op(1, 8'(i), 0, $sformatf("t2_fill%0d", i));
            chk($sformatf("t2_af%0d", i), s_af, 1'((i + 1) >= AF));
            chk($sformatf("t2_full%0d", i), s_full, 1'((i + 1) == DEPTH));
        end
        chk("t2_ae_off", s_ae, 1'b0);
        chk("t2_no_ovf", s_ovf, 1'b0);
        s_op(1, 8'hAA, 0, "t2_over");
        chk("t2_ovf", s_ovf, 1'b1);
        chk("t2_full_hold", s_full, 1'b1);

        // ---- 3: simultaneous read+write while full, then drain through the wrap ----
        s_op(1, 8'h55, 1, "t3_rw");
        chk("t3_pop00", s_rd, 8'h00);
        chk("t3_count16", s_count, 5'd16);
        for (int i = 0; i < 16; i++) begin
            s_op(0, 8'h00, 1, $sformatf("t3_drain%0d", i));
            chk($sformatf("t3_not_aa%0d", i), 1'(s_rd == 8'hAA), 1'b0);
        end
        chk("t3_last55", s_rd, 8'h55);
        chk("t3_empty", s_empty, 1'b1);

        // ---- 5: flush with count=9 and overflow still set ----
        for (int i = 0; i < 9; i++) s_op(1, 8'h20 + 8'(i), 0, $sformatf("t5_w%0d", i));
        chk("t5_pre_ovf", s_ovf, 1'b1);
        s_flush = 1'b1; s_we = 1'b1; s_wd = 8'h99;
        tick();
        s_flush = 1'b0; s_we = 1'b0;
        s_cnt_m = 0;
        sq.delete();
        $display("std flush: count=%0d read_data=%02h", s_count, s_rd);
        chk("t5_count0", s_count, 5'd0);
        chk("t5_empty", s_empty, 1'b1);
        chk("t5_ovf_clr", s_ovf, 1'b0);
        chk("t5_unf_clr", s_unf, 1'b0);
        chk("t5_ae", s_ae, 1'b1);
        chk("t5_rd_held", s_rd, 8'h55);
        s_op(1, 8'h42, 0, "t5_w42");
        s_op(0, 8'h00, 1, "t5_r42");
        chk("t5_pop42", s_rd, 8'h42);

        // ---- 4: FWFT latency and streaming ----
        f_we = 1'b1; f_wd = 8'h3C;
        tick();
        f_we = 1'b0;
        fq.push_back(8'h3C);
        $display("fwft write 3c: empty=%0b count=%0d", f_empty, f_count);
        chk("t4_empty_N", f_empty, 1'b1);
        chk("t4_count_N", f_count, 5'd1);
        tick();
        chk("t4_empty_N1", f_empty, 1'b0);
        chk("t4_head_3c", f_rd, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            f_we = 1'b1; f_wd = 8'h80 + 8'(i);
            fq.push_back(f_wd);
            tick();
            $display("fwft write %02h: count=%0d head=%02h", f_wd, f_count, f_rd);
        end
        f_we = 1'b0;
        chk("t4_count9", f_count, 5'd9);
        chk("t4_head_kept", f_rd, 8'h3C);
        f_re = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] e;
            e = fq.pop_front();
            chk($sformatf("t4_s_empty%0d", i), f_empty, 1'b0);
            chk($sformatf("t4_s_data%0d", i), f_rd, e);
            chk($sformatf("t4_s_count%0d", i), f_count, 5'(9 - i));
            tick();
            $display("fwft pop %02h: count=%0d", e, f_count);
        end
        f_re = 1'b0;
        chk("t4_end_empty", f_empty, 1'b1);
        chk("t4_end_count", f_count, 5'd0);
        chk("t4_no_unf", f_unf, 1'b0);

        // ---- 6: rst mid-stream on both instances ----
        for (int i = 0; i < 5; i++) s_op(1, 8'hC0 + 8'(i), 0, $sformatf("t6_w%0d", i));
        for (int i = 0; i < 5; i++) begin
            f_we = 1'b1; f_wd = 8'hD0 + 8'(i);
            tick();
        end
        f_we = 1'b0;
        tick();
        chk("t6_f_head", f_rd, 8'hD0);
        chk("t6_f_count5", f_count, 5'd5);
        rst = 1'b1;
        s_we = 1'b1; s_re = 1'b1; s_wd = 8'hEE;
        f_we = 1'b1; f_re = 1'b1; f_wd = 8'hEE;
        tick();
        rst = 1'b0;
        s_we = 1'b0; s_re = 1'b0; f_we = 1'b0; f_re = 1'b0;
        s_cnt_m = 0;
        sq.delete();
        $display("reset mid-stream: std count=%0d fwft count=%0d", s_count, f_count);
        chk_reset("t6_std",  s_rd, s_empty, s_full, s_count, s_af, s_ae, s_ovf, s_unf);
        chk_reset("t6_fwft", f_rd, f_empty, f_full, f_count, f_af, f_ae, f_ovf, f_unf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ram_level.md
Name: fifo_ram_level

Overview:
Parametrised successor to the team's fifo_ram, keeping the same write/read/empty/full interface and adding four features:
- occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- synchronous flush;
- selectable standard or first-word-fall-through (FWFT) read mode.
Single clock domain. Sits between producer and consumer stages of the raycaster pipeline, e.g. column results to the display writer.

Parameters:
ADDRBITS, 11, log2 depth; DEPTH = 2**ADDRBITS
DATABITS, 8, word width
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through
AFULL_LEVEL, 2**ADDRBITS-4, almost_full asserts when count >= this
AEMPTY_LEVEL, 4, almost_empty asserts when count <= this

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of contents and flags
write_data  in  DATABITS  word to push
write_en  in  1  push request
read_data  out  DATABITS  popped word (standard) / head word (FWFT)
read_en  in  1  pop request
empty  out  1  no readable word
full  out  1  count == DEPTH
count  out  ADDRBITS+1  words held, 0..DEPTH
almost_full  out  1  count >= AFULL_LEVEL
almost_empty  out  1  count <= AEMPTY_LEVEL
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset values (rst high at an edge): read_data=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Pointers are zeroed; RAM contents are not cleared. rst has priority over flush, read and write.
- flush: same as rst, except read_data holds its value. Any write_en or read_en in the same cycle is ignored and sets no flags.
- Pointers: ADDRBITS-wide read and write pointers that wrap naturally from DEPTH-1 to 0. count is a register; full, empty (standard mode), almost_full and almost_empty decode combinationally from registered state only.
- Accept rules:
  - write accepted = write_en & (!full | read accepted).
  - read accepted = read_en & !empty.
  - Write while full with no accepted read: word dropped, overflow set.
  - Read while empty: ignored, read_data unchanged, underflow set.
  - Simultaneous accepted read and write: count unchanged. This is legal when full; when empty only the write is accepted and underflow is set.
- Standard mode (FWFT=0):
  - A write at edge N makes empty=0 after edge N.
  - An accepted read at edge M loads read_data with the head word at edge M; data is valid from M until the next accepted read.
  - count changes at the same edge as the accepted operation.
- FWFT mode (FWFT=1):
  - An output register holds the head word; empty = !out_valid; count includes the output-register word.
  - A prefetch at edge E loads the output register from RAM when the RAM holds a word written before E, and either out_valid=0 or a read is accepted at E.
  - A write into an empty FIFO at edge N gives read_data = word and empty=0 after edge N+1.
  - Back-to-back reads stream one word per cycle while the RAM is non-empty.
- Thresholds are compared against count after each edge. AFULL_LEVEL must be in 1..DEPTH and AEMPTY_LEVEL in 0..DEPTH-1; other values are a configuration error, checked by an elaboration-time assertion.
- Error flags clear only on rst or flush.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1;
  - a function clog2 for callers;
  - default threshold offsets (AFULL_MARGIN=4, AEMPTY_MARGIN=4).
- One sub-module fifo_ram_dp: simple dual-port synchronous RAM, ADDRBITS x DATABITS, one write port and one registered read port, written to infer block RAM.
- Pointer, count, flag and FWFT prefetch logic stay in fifo_ram_level.

Test Plan:
Benches use ADDRBITS=4 (DEPTH=16), DATABITS=8, AFULL_LEVEL=12, AEMPTY_LEVEL=2 unless a line states otherwise.
1. Standard mode:
   - Write 0x07, then read next cycle -> read_data=0x07 after the read edge, count 1->0, empty=1.
   - Write 0xFA then 0x1B, then 3 reads -> 0xFA, 0x1B, then underflow=1 with read_data held at 0x1B.
2. Fill: write 16 words 0x00..0x0F ->
   - almost_full=1 once count=12; full=1 at count=16.
   - A 17th write (0xAA) -> overflow=1, count stays 16.
   - Draining returns 0x00..0x0F in order and never returns 0xAA.
3. Full with simultaneous read+write of 0x55 -> count stays 16, next popped word 0x00; after wrap, 0x55 pops as the 16th word.
4. FWFT=1:
   - Write 0x3C at edge N -> empty=0 and read_data=0x3C after N+1.
   - Then 8 writes and read_en held high -> one word per cycle in order, with empty=1 after the last word.
5. Flush with count=9 and overflow=1 -> after the edge: count=0, empty=1, overflow=0, almost_empty=1; a write_en in the flush cycle is not stored.
6. rst asserted mid-stream, with read_en and write_en high and count=5 -> all outputs at reset values after the edge, including read_data=0.
